// File: rtl/ysyx_23060075_gpr_sb.sv
// Register file with per-register busy scoreboard.
// Combinational reads, one write-back port, optional write bypass.
module ysyx_23060075_gpr_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NR_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NR_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NR_RD-1:0]            rd_ready,
  input  logic                        wb_en,
  input  logic [ADDR_WIDTH-1:0]       wb_addr,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        rsv_en,
  input  logic [ADDR_WIDTH-1:0]       rsv_addr,
  input  logic                        flush,
  output logic [ADDR_WIDTH:0]         busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  wb_hit;
  logic                  rsv_hit;

  assign wb_hit  = wb_en && (wb_addr != '0);
  assign rsv_hit = rsv_en && (rsv_addr != '0);

  // Next busy vector: flush dominates, then retire, then reserve.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_hit)
        busy_nxt[wb_addr] = 1'b0;
      if (rsv_hit)
        busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector feeds the registered count.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  // Busy vector and its count update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Register storage; index 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NR_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  byp;

    assign a   = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign byp = (BYPASS != 0) && wb_en && (wb_addr == a);

    // Read mux: x0, then same-cycle bypass, then stored value.
    always_comb begin
      rd_data[g*DATA_WIDTH +: DATA_WIDTH] = regs[a];
      rd_ready[g] = !busy[a];
      if (a == '0) begin
        rd_data[g*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_ready[g] = 1'b1;
      end else if (byp) begin
        rd_data[g*DATA_WIDTH +: DATA_WIDTH] = wb_data;
        rd_ready[g] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060075_gpr_sb.sv
// Bench for ysyx_23060075_gpr_sb: vector table plus
// hand sequences for no-bypass and async reset.
module tb_ysyx_23060075_gpr_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        flush = 1'b0;

  logic [63:0] rd_data0, rd_data1;
  logic [1:0]  rd_ready0, rd_ready1;
  logic [5:0]  busy_cnt0, busy_cnt1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ysyx_23060075_gpr_sb #(.BYPASS(1)) dut0 (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_ready(rd_ready0),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .busy_cnt(busy_cnt0)
  );

  ysyx_23060075_gpr_sb #(.BYPASS(0)) dut1 (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_ready(rd_ready1),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush), .busy_cnt(busy_cnt1)
  );

  typedef struct {
    string       nm;
    logic        rs;
    logic [4:0]  ra;
    logic        wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic        r0;
    logic [31:0] d1;
    logic        r1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t       tbl [$];
  logic [5:0] sb  [$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic add(string nm, bit rs, int ra,
                     bit wb, int wa, logic [31:0] wd,
                     bit fl, int a0, int a1,
                     logic [31:0] d0, bit r0,
                     logic [31:0] d1, bit r1, int cnt);
    vec_t v;
    v.nm = nm; v.rs = rs; v.ra = 5'(ra);
    v.wb = wb; v.wa = 5'(wa); v.wd = wd;
    v.fl = fl; v.a0 = 5'(a0); v.a1 = 5'(a1);
    v.d0 = d0; v.r0 = r0; v.d1 = d1; v.r1 = r1;
    v.cnt = 6'(cnt);
    tbl.push_back(v);
  endtask

  task automatic drive(bit rs, int ra, bit wb, int wa,
                       logic [31:0] wd, bit fl,
                       int a0, int a1);
    rsv_en = rs; rsv_addr = 5'(ra);
    wb_en = wb; wb_addr = 5'(wa); wb_data = wd;
    flush = fl;
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(vec_t v);
    logic [5:0] e;
    drive(v.rs, v.ra, v.wb, v.wa, v.wd, v.fl,
          v.a0, v.a1);
    #1;
    chk({v.nm, " d0"}, rd_data0[31:0], v.d0);
    chk({v.nm, " r0"}, 32'(rd_ready0[0]), 32'(v.r0));
    chk({v.nm, " d1"}, rd_data0[63:32], v.d1);
    chk({v.nm, " r1"}, 32'(rd_ready0[1]), 32'(v.r1));
    sb.push_back(v.cnt);
    step();
    e = sb.pop_front();
    chk({v.nm, " cnt"}, 32'(busy_cnt0), 32'(e));
    chk({v.nm, " cnt_nb"}, 32'(busy_cnt1), 32'(e));
  endtask

  initial begin
    add("x0wr",  0,0,  1,0,32'hDEADBEEF, 0, 0,0,
        32'h0,1, 32'h0,1, 0);
    add("rsv5",  1,5,  0,0,32'h0, 0, 5,1,
        32'h0,1, 32'h0,1, 1);
    add("c1",    0,0,  0,0,32'h0, 0, 5,0,
        32'h0,0, 32'h0,1, 1);
    add("c2",    0,0,  0,0,32'h0, 0, 5,0,
        32'h0,0, 32'h0,1, 1);
    add("wb5",   0,0,  1,5,32'h12345678, 0, 5,5,
        32'h12345678,1, 32'h12345678,1, 0);
    add("rd5",   0,0,  0,0,32'h0, 0, 5,0,
        32'h12345678,1, 32'h0,1, 0);
    add("rsv7",  1,7,  0,0,32'h0, 0, 7,0,
        32'h0,1, 32'h0,1, 1);
    add("rw7",   1,7,  1,7,32'hA5A5A5A5, 0, 7,5,
        32'hA5A5A5A5,1, 32'h12345678,1, 1);
    add("rd7",   0,0,  0,0,32'h0, 0, 7,7,
        32'hA5A5A5A5,0, 32'hA5A5A5A5,0, 1);
    add("rersv", 1,7,  0,0,32'h0, 0, 7,0,
        32'hA5A5A5A5,0, 32'h0,1, 1);
    add("ret7",  0,0,  1,7,32'hA5A5A5A5, 0, 7,0,
        32'hA5A5A5A5,1, 32'h0,1, 0);
    add("wb1",   0,0,  1,1,32'h11111111, 0, 1,2,
        32'h11111111,1, 32'h0,1, 0);
    add("wb2",   0,0,  1,2,32'h22222222, 0, 1,2,
        32'h11111111,1, 32'h22222222,1, 0);
    add("wb3",   0,0,  1,3,32'h33333333, 0, 3,2,
        32'h33333333,1, 32'h22222222,1, 0);
    add("rsv1",  1,1,  0,0,32'h0, 0, 1,0,
        32'h11111111,1, 32'h0,1, 1);
    add("rsv2",  1,2,  0,0,32'h0, 0, 1,2,
        32'h11111111,0, 32'h22222222,1, 2);
    add("rsv3",  1,3,  0,0,32'h0, 0, 2,3,
        32'h22222222,0, 32'h33333333,1, 3);
    add("flush", 1,4,  0,0,32'h0, 1, 3,4,
        32'h33333333,0, 32'h0,1, 0);
    add("pf1",   0,0,  0,0,32'h0, 0, 1,4,
        32'h11111111,1, 32'h0,1, 0);
    add("pf2",   0,0,  0,0,32'h0, 0, 2,3,
        32'h22222222,1, 32'h33333333,1, 0);
    add("mix",   1,4,  1,31,32'hFFFFFFFF, 0, 31,4,
        32'hFFFFFFFF,1, 32'h0,1, 1);
    add("pmix",  0,0,  0,0,32'h0, 0, 31,4,
        32'hFFFFFFFF,1, 32'h0,0, 1);

    drive(0,0, 0,0,32'h0, 0, 0,0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst cnt", 32'(busy_cnt0), 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("rst d x%0d", a), rd_data0[31:0], 32'h0);
      chk($sformatf("rst d1 x%0d", 31 - a),
          rd_data0[63:32], 32'h0);
      chk($sformatf("rst rdy x%0d", a),
          32'(rd_ready0), 32'h3);
    end
    step();

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i]);

    drive(0,0, 1,9,32'h55, 0, 0,9);
    #1;
    chk("nb old", rd_data1[63:32], 32'h0);
    chk("byp new", rd_data0[63:32], 32'h55);
    step();
    drive(0,0, 1,9,32'h66, 0, 0,9);
    #1;
    chk("nb next", rd_data1[63:32], 32'h55);
    step();
    drive(0,0, 0,0,32'h0, 0, 0,9);
    #1;
    chk("nb after", rd_data1[63:32], 32'h66);

    drive(1,10, 0,0,32'h0, 0, 31,10);
    step();
    drive(1,11, 0,0,32'h0, 0, 31,10);
    step();
    drive(1,12, 0,0,32'h0, 0, 31,10);
    step();
    drive(0,0, 0,0,32'h0, 0, 31,10);
    #1;
    chk("pre rst cnt", 32'(busy_cnt0), 32'h4);
    chk("pre rst d", rd_data0[31:0], 32'hFFFFFFFF);
    chk("pre rst r", 32'(rd_ready0[1]), 32'h0);
    rst = 1'b1;
    #1;
    chk("arst cnt", 32'(busy_cnt0), 32'h0);
    chk("arst cnt nb", 32'(busy_cnt1), 32'h0);
    chk("arst d0", rd_data0[31:0], 32'h0);
    chk("arst d1", rd_data1[31:0], 32'h0);
    chk("arst rdy", 32'(rd_ready0), 32'h3);
    rst = 1'b0;
    step();
    chk("post rst cnt", 32'(busy_cnt0), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_23060075_gpr_sb.md
# ysyx_23060075_gpr_sb

Parametrised general-purpose register file with an integrated scoreboard, used in the pipelined core between decode/issue and writeback. It provides `NR_RD` combinational read ports, one write-back port with optional same-cycle write-to-read bypass, and a per-register busy bit. Issue sets busy bits by reservation; writeback and flush clear them. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: register index width. Depth is 2^ADDR_WIDTH; use 4 for RV32E.
- `DATA_WIDTH`, default 32: register width.
- `NR_RD`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: when 1, write-back data is forwarded to reads in the same cycle.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `rd_addr`  in  NR_RD*ADDR_WIDTH: read indices; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_data`  out  NR_RD*DATA_WIDTH: read data, sliced the same way.
- `rd_ready`  out  NR_RD: operand on port i is valid this cycle.
- `wb_en`  in  1: write-back strobe.
- `wb_addr`  in  ADDR_WIDTH: write-back index.
- `wb_data`  in  DATA_WIDTH: write-back data.
- `rsv_en`  in  1: reserve the destination register, i.e. set its busy bit.
- `rsv_addr`  in  ADDR_WIDTH: index to reserve.
- `flush`  in  1: clear all busy bits. Register contents are unaffected.
- `busy_cnt`  out  ADDR_WIDTH+1: number of busy registers (registered).

## Operation
- **Storage.** Register array `regs[0..2^ADDR_WIDTH-1]` and busy vector `busy[...]`.
- **Reset.** Asynchronous on `rst`. All `regs` are set to 0, all `busy` bits to 0, and `busy_cnt` to 0.
  - `rd_data` after reset is 0 for every address.
  - `rd_ready` after reset is all-ones.
- **Read, port i, address a.** Combinational.
  - If a==0: `rd_data`=0 and `rd_ready`=1.
  - Else if BYPASS and `wb_en` and `wb_addr`==a: `rd_data`=`wb_data` and `rd_ready`=1.
  - Else: `rd_data`=`regs[a]` and `rd_ready`=!`busy[a]`.
- **Write.** When `wb_en` is high and `wb_addr`!=0, `regs[wb_addr]` takes `wb_data` at the clock edge. A write to index 0 is discarded.
  - A write to a non-busy register is legal and simply updates it.
- **Busy update** at the clock edge, in priority order:
  1. `flush`: all busy bits become 0. A `rsv_en` in the same cycle is ignored.
  2. Otherwise, if `wb_en` and `wb_addr`!=0: `busy[wb_addr]` is cleared.
  3. Then, if `rsv_en` and `rsv_addr`!=0: `busy[rsv_addr]` is set. When `rsv_addr`==`wb_addr`, the set wins, so a new producer can reserve a register while the old one retires.
- **Reservation of index 0** is a no-op.
- **Re-reservation.** Reserving an already-busy register leaves it busy. `busy_cnt` is unchanged in that case.
- **`busy_cnt`** always equals the popcount of the next-state busy vector; it is a register and never wraps.
  - Maximum value is 2^ADDR_WIDTH-1, since index 0 is never busy.
- **Read/write timing.** Reads reflect `busy` and `regs` as they stand in the current cycle. A reservation made this cycle is not visible to reads until the next cycle.
- **X-safety.** `rd_data` for an address that is not ready still returns the stored value; no X is generated.

## Timing
- **Read latency.** Zero cycles (combinational from `rd_addr`, `wb_*`, `regs`, `busy`).
- **Write latency.** One edge. With BYPASS=0 the data is visible on a read in the cycle after `wb_en`.
- **Busy latency.** The busy set/clear becomes visible on `rd_ready` one cycle after `rsv_en`/`wb_en`. With BYPASS=1, `rd_ready` also rises in the same cycle as `wb_en`.
- **`busy_cnt` latency.** Updated at the same edge as the busy vector.
- **Reset mid-operation.** `rst` asserted at any point forces the reset state immediately, without waiting for `clk`. Pending reservations are lost.
- **Register count.** No handshakes; the block always accepts `wb_en` and `rsv_en`. Back-to-back reservations, one per cycle, raise `busy_cnt` by 1 per cycle.

## Test plan
- **Reset and x0 behaviour.** Assert `rst`, release it, then read all addresses on every port. Require `rd_data`=0, `rd_ready`=1 and `busy_cnt`=0. Then apply `wb_en`, `wb_addr`=0, `wb_data`=0xDEADBEEF; reading x0 must still return 0.
- **Reserve then write back.** `rsv_en`, `rsv_addr`=5 at cycle 0.
  - Cycle 1: port0 on x5 reads `rd_ready`=0 and `busy_cnt`=1.
  - Cycle 3: `wb_en` to x5 with 0x12345678. With BYPASS=1, port0 reads 0x12345678 and `rd_ready`=1 in cycle 3.
  - Cycle 4: `busy_cnt`=0.
- **Simultaneous reserve and write-back to the same register.** Apply `rsv_en` and `wb_en` to x7 in the same cycle with data 0xA5A5A5A5. Next cycle: `regs[7]`=0xA5A5A5A5, x7 is still busy, and `busy_cnt` is unchanged.
- **Flush.** Reserve x1, x2, x3 in consecutive cycles, giving `busy_cnt`=3. Then assert `flush` together with `rsv_en` x4. Next cycle: `busy_cnt`=0, all ports report ready, and the contents of x1..x3 are unchanged.
- **No bypass.** With BYPASS=0, write x9 with 0x55 while port1 reads x9. Port1 shows the old value that cycle and 0x55 the next cycle.
- **Async reset mid-operation.** With 4 registers busy, pulse `rst` between clock edges. `busy_cnt` must go to 0 and all `rd_data` to 0 before the next edge.
